// File: rtl/vga_vram_pkg.sv
// Package for the VGA video-RAM responder.
// Holds the CPU-side FSM state encoding, the default video read latency
// and the data-width constant shared by the top level and the RAM.
package vga_vram_pkg;

  localparam int DW           = 16;
  localparam int READ_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_ACK    = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/vga_vram_sp.sv
// Single-port RAM, 2**AW x 16, byte write enables, registered read.
// Ports:
//   clk    in  system clock
//   en     in  access enable (read when we=0)
//   we     in  write enable
//   be     in  byte enables: [0]=bits 7:0, [1]=bits 15:8
//   adr    in  word address
//   wdat   in  write data
//   rdat   out read data, valid the cycle after a read access
// Contents are never cleared.
module vga_vram_sp
  import vga_vram_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdat_q, rdat_d;

  always_ff @(posedge clk) begin
    if (en && we) begin
      if (be[0]) mem[adr][7:0]  <= wdat[7:0];
      if (be[1]) mem[adr][15:8] <= wdat[15:8];
    end
  end

  always_comb begin
    rdat_d = rdat_q;
    if (en && !we) rdat_d = mem[adr];
  end

  always_ff @(posedge clk) begin
    rdat_q <= rdat_d;
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/vga_vram_responder.sv
// Video-RAM responder: memory end of the VGA sequencer's FML read port,
// sharing one single-port RAM with a Wishbone CPU slave port.
// Video reads have absolute priority and a fixed READ_LAT latency; the CPU
// only gets the RAM in cycles without a video strobe.
// Optional feature macro: VGA_VRAM_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of cycles where a CPU request was blocked by video.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fml_adr_i/stb_i     video read address / request (no handshake)
//   fml_dat_o           video read data, READ_LAT cycles after stb
//   wb_adr_i/dat_i      CPU word address / write data
//   wb_sel_i/we_i       byte enables / write select
//   wb_stb_i/cyc_i      CPU strobe / cycle
//   wb_dat_o/ack_o      CPU read data / one-cycle acknowledge
//   stall_cnt_o         (macro only) blocked-request cycle count
//
// state     | meaning
// ST_IDLE   | waiting for a CPU request in a cycle without video strobe
// ST_RDWAIT | CPU read issued, RAM output captured this cycle
// ST_ACK    | acknowledge for one cycle, no new issue possible
module vga_vram_responder
  import vga_vram_pkg::*;
#(
  parameter int AW       = 17,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [AW:1] fml_adr_i,
  input  logic        fml_stb_i,
  output logic [15:0] fml_dat_o,
  input  logic [AW:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o
`ifdef VGA_VRAM_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  // Pipeline stages after the RAM's own output register.
  localparam int NP = READ_LAT - 1;

  cpu_state_e    state_q, state_d;
  logic [DW-1:0] wb_dat_q, wb_dat_d;
  logic          cpu_req, cpu_issue;

  logic          ram_en, ram_we;
  logic [1:0]    ram_be;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_rdat;

  logic [NP-1:0] vld_q, vld_d;
  logic [DW-1:0] vdat_q [NP];
  logic [DW-1:0] vdat_d [NP];

  assign cpu_req = wb_cyc_i & wb_stb_i;

  always_comb begin
    state_d   = state_q;
    wb_dat_d  = wb_dat_q;
    cpu_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !fml_stb_i) begin
          cpu_issue = 1'b1;
          state_d   = wb_we_i ? ST_ACK : ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        wb_dat_d = ram_rdat;
        state_d  = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wb_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      wb_dat_q <= wb_dat_d;
    end
  end

  assign wb_ack_o = (state_q == ST_ACK);
  assign wb_dat_o = wb_dat_q;

  // Video strobe owns the port; cpu_issue already excludes fml_stb_i.
  always_comb begin
    ram_adr = fml_stb_i ? fml_adr_i : wb_adr_i;
    ram_en  = fml_stb_i | cpu_issue;
    ram_we  = cpu_issue & wb_we_i;
    ram_be  = wb_sel_i;
  end

  vga_vram_sp #(.AW(AW)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .adr  (ram_adr),
    .wdat (wb_dat_i),
    .rdat (ram_rdat)
  );

  // Each stage loads only when valid data reaches it, so the last stage
  // holds its value between video reads and CPU reads never leak out.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = fml_stb_i;
    for (int i = 1; i < NP; i++) vld_d[i] = vld_q[i-1];
    vdat_d = vdat_q;
    if (vld_q[0]) vdat_d[0] = ram_rdat;
    for (int i = 1; i < NP; i++) begin
      if (vld_q[i]) vdat_d[i] = vdat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < NP; i++) vdat_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      vdat_q <= vdat_d;
    end
  end

  assign fml_dat_o = vdat_q[NP-1];

`ifdef VGA_VRAM_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && cpu_req && fml_stb_i && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vga_vram_responder.sv
// Directed testbench for vga_vram_responder (AW=17, READ_LAT=2).
// Inputs change 1 time unit after posedge; outputs are sampled there too,
// so "cycle N" is the interval in which an input is held before the edge
// that samples it.
module tb_vga_vram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] fml_adr;
  logic        fml_stb;
  logic [15:0] fml_dat_o;
  logic [16:0] wb_adr;
  logic [15:0] wb_dat;
  logic [1:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o;
`ifdef VGA_VRAM_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_vram_responder dut (
    .clk         (clk),
    .rst         (rst),
    .fml_adr_i   (fml_adr),
    .fml_stb_i   (fml_stb),
    .fml_dat_o   (fml_dat_o),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat),
    .wb_sel_i    (wb_sel),
    .wb_we_i     (wb_we),
    .wb_stb_i    (wb_stb),
    .wb_cyc_i    (wb_cyc),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o)
`ifdef VGA_VRAM_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request in the current cycle, returns read data and the
  // number of cycles from issue to ack; ends one cycle after the ack.
  task automatic wb_access(input logic we, input logic [16:0] adr, input logic [15:0] dat,
                           input logic [1:0] sel, output logic [15:0] rdat, output int lat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_dat = dat; wb_sel = sel;
    lat = 0; rdat = '0;
    while (!wb_ack_o && lat < 50) begin
      tick();
      lat++;
    end
    if (!wb_ack_o) check("wb_ack_timeout", 32'(wb_ack_o), 32'd1);
    else rdat = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick();
  endtask

  task automatic fml_read(input string tag, input logic [16:0] adr, input logic [15:0] exp);
    fml_stb = 1'b1; fml_adr = adr;
    tick();
    fml_stb = 1'b0;
    tick();
    check(tag, 32'(fml_dat_o), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int          lat;

    rst = 1'b1; fml_stb = 1'b0; fml_adr = '0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0;
    tick(); tick();
    check("rst_fml_dat", 32'(fml_dat_o), 32'h0);
    check("rst_wb_dat", 32'(wb_dat_o), 32'h0);
    check("rst_wb_ack", 32'(wb_ack_o), 32'h0);
`ifdef VGA_VRAM_STALL_CNT_EN
    check("rst_stall", 32'(stall_cnt_o), 32'h0);
`endif
    rst = 1'b0;
    tick();

    // 1: full write, latency 1, then video read
    wb_access(1'b1, 17'h00010, 16'h1234, 2'b11, rd, lat);
    check("t1_wr_lat", 32'(lat), 32'd1);
    fml_read("t1_fml_dat", 17'h00010, 16'h1234);

    // 2: low-byte write then CPU read, latency 2
    wb_access(1'b1, 17'h00010, 16'h00CD, 2'b01, rd, lat);
    check("t2_wr_lat", 32'(lat), 32'd1);
    wb_access(1'b0, 17'h00010, 16'h0000, 2'b11, rd, lat);
    check("t2_rd_dat", 32'(rd), 32'h12CD);
    check("t2_rd_lat", 32'(lat), 32'd2);

    // 3: back-to-back video burst
    for (int i = 0; i < 4; i++) begin
      wb_access(1'b1, 17'(i), 16'hA000 + 16'(i), 2'b11, rd, lat);
    end
    for (int i = 0; i < 7; i++) begin
      fml_stb = (i < 4);
      fml_adr = 17'(i);
      if (i >= 2) check($sformatf("t3_burst_%0d", i), 32'(fml_dat_o), 32'hA000 + 32'((i > 5) ? 3 : i - 2));
      tick();
    end

    // 4: CPU write blocked by a 10-cycle video burst on the same word
    wb_access(1'b1, 17'h00020, 16'h5555, 2'b11, rd, lat);
    for (int i = 0; i < 12; i++) begin
      fml_stb = (i < 10);
      fml_adr = 17'h00020;
      if (i == 0) begin
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 17'h00020; wb_dat = 16'hBEEF; wb_sel = 2'b11;
      end
      if (i <= 10) check($sformatf("t4_no_ack_%0d", i), 32'(wb_ack_o), 32'h0);
      if (i == 11) check("t4_ack", 32'(wb_ack_o), 32'h1);
      if (i >= 2) check($sformatf("t4_fml_%0d", i), 32'(fml_dat_o), 32'h5555);
      if (i == 11) begin
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      end
      tick();
    end
`ifdef VGA_VRAM_STALL_CNT_EN
    check("t4_stall_cnt", 32'(stall_cnt_o), 32'd10);
`endif
    fml_read("t4_after_wr", 17'h00020, 16'hBEEF);

    // 5: reset while in RDWAIT with a video read in flight
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 17'h00010;
    tick();
    rst = 1'b1; fml_stb = 1'b1; fml_adr = 17'h00020;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick();
    rst = 1'b0; fml_stb = 1'b0;
    check("t5_ack_r2", 32'(wb_ack_o), 32'h0);
    check("t5_fml_r2", 32'(fml_dat_o), 32'h0);
    check("t5_wbdat_r2", 32'(wb_dat_o), 32'h0);
`ifdef VGA_VRAM_STALL_CNT_EN
    check("t5_stall_clr", 32'(stall_cnt_o), 32'h0);
`endif
    tick();
    check("t5_ack_r3", 32'(wb_ack_o), 32'h0);
    check("t5_fml_r3", 32'(fml_dat_o), 32'h0);
    wb_access(1'b0, 17'h00010, 16'h0000, 2'b11, rd, lat);
    check("t5_rd_dat", 32'(rd), 32'h12CD);
    check("t5_rd_lat", 32'(lat), 32'd2);

    // 6: CPU write at N, video read of the same word at N+1
    wb_access(1'b1, 17'h00030, 16'h1111, 2'b11, rd, lat);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 17'h00030; wb_dat = 16'h7777; wb_sel = 2'b11;
    tick();
    check("t6_ack", 32'(wb_ack_o), 32'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    fml_stb = 1'b1; fml_adr = 17'h00030;
    tick();
    fml_stb = 1'b0;
    tick();
    check("t6_fml_new", 32'(fml_dat_o), 32'h7777);

    // blocked write abandoned by dropping cyc: no ack, no write
    fml_stb = 1'b1; fml_adr = 17'h00030;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 17'h00030; wb_dat = 16'h9999; wb_sel = 2'b11;
    tick();
    check("ab_ack_0", 32'(wb_ack_o), 32'h0);
    tick();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; fml_stb = 1'b0;
    check("ab_ack_1", 32'(wb_ack_o), 32'h0);
    tick();
    check("ab_ack_2", 32'(wb_ack_o), 32'h0);
    fml_read("ab_no_write", 17'h00030, 16'h7777);

    // high-byte-only write
    wb_access(1'b1, 17'h00010, 16'hAB55, 2'b10, rd, lat);
    wb_access(1'b0, 17'h00010, 16'h0000, 2'b11, rd, lat);
    check("hi_byte_rd", 32'(rd), 32'hABCD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
